// File: rtl/jump_game_pkg.sv
// Shared encodings, widths and default tuning values for the jump game controller.
package jump_game_pkg;

  localparam int POS_W    = 32;
  localparam int CHARGE_W = 8;
  localparam int SCORE_W  = 16;

  localparam int CHARGE_DIV_DEF = 131072;
  localparam int STEP_DIV_DEF   = 65536;
  localparam int MAX_DIST_DEF   = 255;
  localparam int LAND_TOL_DEF   = 16;
  localparam int SCORE_MAX_DEF  = 65535;

  localparam logic BOX_INIT = 1'b0;
  localparam logic BOX_RELD = 1'b1;

  typedef enum logic [2:0] {
    ST_BOOT   = 3'd0,
    ST_IDLE   = 3'd1,
    ST_CHARGE = 3'd2,
    ST_JUMP   = 3'd3,
    ST_CHECK  = 3'd4,
    ST_RELOAD = 3'd5,
    ST_OVER   = 3'd6
  } state_t;

endpackage

// File: rtl/prescale_tick.sv
// Free-running divider that emits a one-cycle tick every DIV enabled cycles;
// clear restarts the count so the first tick lands DIV cycles after clear drops.
module prescale_tick #(
  parameter int DIV = 2
) (
  input  logic clk_machine,
  input  logic rst_machine,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= (count == LAST) ? '0 : count + CW'(1);
    end
  end

  assign tick = enable && !clear && (count == LAST);

endmodule

// File: rtl/jump_game_ctrl.sv
// Game-control FSM: turns a button hold into a jump, scores landings on block 2
// and drives the box positioner's INIT/RELD reload handshake.
module jump_game_ctrl
  import jump_game_pkg::*;
#(
  parameter int CHARGE_DIV = CHARGE_DIV_DEF,
  parameter int STEP_DIV   = STEP_DIV_DEF,
  parameter int MAX_DIST   = MAX_DIST_DEF,
  parameter int LAND_TOL   = LAND_TOL_DEF,
  parameter int SCORE_MAX  = SCORE_MAX_DEF
) (
  input  logic                clk_machine,
  input  logic                rst_machine,
  input  logic                i_btn,
  input  logic [POS_W-1:0]    i_x_block1,
  input  logic [POS_W-1:0]    i_x_block2,
  input  logic                i_en_block2,
  input  logic                i_reload_done,
  output logic                o_state_box,
  output logic [POS_W-1:0]    o_player_x,
  output logic [CHARGE_W-1:0] o_charge,
  output logic                o_jumping,
  output logic [SCORE_W-1:0]  o_score,
  output logic                o_game_over,
  output logic [2:0]          o_fsm_state
);

  state_t              state, state_next;
  logic                btn_prev;
  logic [POS_W-1:0]    target, target_next;
  logic [POS_W-1:0]    x_next;
  logic [CHARGE_W-1:0] charge_next, charge_inc;
  logic [SCORE_W-1:0]  score_next;
  logic [POS_W-1:0]    diff;
  logic                btn_rise;
  logic                charge_tick, step_tick;

  assign btn_rise = i_btn && !btn_prev;
  assign diff = (o_player_x >= i_x_block2) ? (o_player_x - i_x_block2)
                                           : (i_x_block2 - o_player_x);

  prescale_tick #(.DIV(CHARGE_DIV)) u_charge_tick (
    .clk_machine (clk_machine),
    .rst_machine (rst_machine),
    .clear       (state != ST_CHARGE),
    .enable      (state == ST_CHARGE),
    .tick        (charge_tick)
  );

  prescale_tick #(.DIV(STEP_DIV)) u_step_tick (
    .clk_machine (clk_machine),
    .rst_machine (rst_machine),
    .clear       (state != ST_JUMP),
    .enable      (state == ST_JUMP),
    .tick        (step_tick)
  );

  always_comb begin
    state_next  = state;
    x_next      = o_player_x;
    charge_next = o_charge;
    score_next  = o_score;
    target_next = target;
    charge_inc  = o_charge;
    case (state)
      ST_BOOT: state_next = ST_RELOAD;
      ST_RELOAD: begin
        if (i_reload_done) begin
          state_next  = ST_IDLE;
          x_next      = '0;
          charge_next = '0;
        end else begin
          x_next = i_x_block1;
        end
      end
      ST_IDLE: begin
        if (btn_rise) state_next = ST_CHARGE;
      end
      ST_CHARGE: begin
        // A tick coinciding with release still counts toward the jump distance.
        if (charge_tick && (o_charge < CHARGE_W'(MAX_DIST)))
          charge_inc = o_charge + CHARGE_W'(1);
        charge_next = charge_inc;
        if (!i_btn) begin
          state_next  = ST_JUMP;
          target_next = o_player_x + POS_W'(charge_inc);
        end
      end
      ST_JUMP: begin
        if (o_player_x == target) state_next = ST_CHECK;
        else if (step_tick) x_next = o_player_x + POS_W'(1);
      end
      ST_CHECK: begin
        if (i_en_block2 && (diff <= POS_W'(LAND_TOL))) begin
          if (o_score < SCORE_W'(SCORE_MAX)) score_next = o_score + SCORE_W'(1);
          state_next = ST_RELOAD;
        end else begin
          state_next = ST_OVER;
        end
      end
      ST_OVER: begin
        if (btn_rise) begin
          score_next = '0;
          x_next     = '0;
          state_next = ST_RELOAD;
        end
      end
      default: state_next = ST_BOOT;
    endcase
  end

  // Flag outputs are registered from the next state so they line up with o_fsm_state.
  always_ff @(posedge clk_machine or posedge rst_machine) begin
    if (rst_machine) begin
      state       <= ST_BOOT;
      btn_prev    <= 1'b0;
      target      <= '0;
      o_state_box <= BOX_INIT;
      o_player_x  <= '0;
      o_charge    <= '0;
      o_jumping   <= 1'b0;
      o_score     <= '0;
      o_game_over <= 1'b0;
    end else begin
      state       <= state_next;
      btn_prev    <= i_btn;
      target      <= target_next;
      o_state_box <= (state_next == ST_RELOAD) ? BOX_RELD : BOX_INIT;
      o_player_x  <= x_next;
      o_charge    <= charge_next;
      o_jumping   <= (state_next == ST_JUMP);
      o_score     <= score_next;
      o_game_over <= (state_next == ST_OVER);
    end
  end

  assign o_fsm_state = state;

endmodule
